// File: rtl/enc_pkg.sv
// Shared helpers for the pipelined priority encoder: index width, multi-hot
// detection and the result record.
package enc_pkg;

    localparam int MAX_WIDTH = 256;
    localparam int MAX_IDX_W = 8;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] idx;
        logic                 zero;
        logic                 multi;
    } enc_result_t;

    function automatic int idx_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // Narrower vectors are zero-extended by the caller, so extra bits never count.
    function automatic logic is_multi(input logic [MAX_WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            n = n + int'(v[i]);
        end
        return (n >= 2);
    endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority encode of one request vector into index and
// zero/multi-hot flags.
module prio_enc_core
    import enc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MSB_PRIO = 1,
    parameter int IDX_W    = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [IDX_W-1:0] idx,
    output logic             zero,
    output logic             multi
);

    // The scan direction makes the last hit the winner, so the loop order
    // alone selects MSB or LSB priority.
    always_comb begin
        idx = '0;
        if (MSB_PRIO != 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_vec[i]) idx = IDX_W'(i);
            end
        end
    end

    assign zero  = ~|in_vec;
    assign multi = is_multi(MAX_WIDTH'(in_vec));

endmodule

// File: rtl/prio_encoder_pipe.sv
// Registered priority encoder with a one-deep valid/ready output stage and a
// saturating multi-hot error counter.
module prio_encoder_pipe
    import enc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_PRIO  = 1,
    parameter int ERR_CNT_W = 8,
    localparam int IDX_W    = idx_w(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_vec,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_zero,
    output logic                 out_multi,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    logic [IDX_W-1:0] core_idx;
    logic             core_zero;
    logic             core_multi;
    logic             accept;

    prio_enc_core #(
        .WIDTH   (WIDTH),
        .MSB_PRIO(MSB_PRIO),
        .IDX_W   (IDX_W)
    ) u_core (
        .in_vec(in_vec),
        .idx   (core_idx),
        .zero  (core_zero),
        .multi (core_multi)
    );

    // Handshake: a beat moves when valid && ready on that side. The output
    // register frees up in the same cycle it is drained, so in_ready looks
    // straight through to out_ready and sustains one result per clock.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_zero  <= 1'b0;
            out_multi <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_idx   <= core_idx;
            out_zero  <= core_zero;
            out_multi <= core_multi;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt <= '0;
        end else if (accept && core_multi && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Bench for prio_encoder_pipe: three builds (8-bit MSB-first, 8-bit LSB-first,
// 5-bit with 2-bit counter) share one stimulus stream and one reference model.
module tb_prio_encoder_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_vec;
    logic       in_valid;
    logic       out_ready;
    logic       err_clr;

    logic       ov[3];
    logic       ir[3];
    logic       oz[3];
    logic       om[3];
    logic [2:0] oi[3];
    logic [7:0] ec[3];
    logic [1:0] ec_small;

    int vectors     = 0;
    int miscompares = 0;
    bit en          = 1'b0;

    // model state per build
    int   w_of[3]   = '{8, 8, 5};
    bit   msb_of[3] = '{1'b1, 1'b0, 1'b1};
    int   cmax[3]   = '{255, 255, 3};
    bit   mv[3];
    int   midx[3];
    bit   mz[3];
    bit   mm[3];
    int   mcnt[3];

    always #5 clk = ~clk;

    prio_encoder_pipe #(.WIDTH(8), .MSB_PRIO(1), .ERR_CNT_W(8)) dut_msb (
        .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(ir[0]),
        .out_idx(oi[0]), .out_zero(oz[0]), .out_multi(om[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .err_cnt(ec[0]), .err_clr(err_clr)
    );

    prio_encoder_pipe #(.WIDTH(8), .MSB_PRIO(0), .ERR_CNT_W(8)) dut_lsb (
        .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid), .in_ready(ir[1]),
        .out_idx(oi[1]), .out_zero(oz[1]), .out_multi(om[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .err_cnt(ec[1]), .err_clr(err_clr)
    );

    prio_encoder_pipe #(.WIDTH(5), .MSB_PRIO(1), .ERR_CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_vec(in_vec[4:0]), .in_valid(in_valid), .in_ready(ir[2]),
        .out_idx(oi[2]), .out_zero(oz[2]), .out_multi(om[2]), .out_valid(ov[2]),
        .out_ready(out_ready), .err_cnt(ec_small), .err_clr(err_clr)
    );
    assign ec[2] = {6'b0, ec_small};

    function automatic int ref_idx(input logic [7:0] v, input int w, input bit msb);
        if (msb) begin
            for (int i = w - 1; i >= 0; i--) if (v[i]) return i;
        end else begin
            for (int i = 0; i < w; i++) if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a one-entry holding register per build, driven from the rules.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            logic [7:0] v;
            bit         rdy;
            bit         acc;
            v = in_vec & 8'((1 << w_of[d]) - 1);
            if (rst) begin
                mv[d] = 0; midx[d] = 0; mz[d] = 0; mm[d] = 0; mcnt[d] = 0;
            end else begin
                rdy = !mv[d] || out_ready;
                acc = in_valid && rdy;
                if (err_clr) mcnt[d] = 0;
                else if (acc && $countones(v) >= 2 && mcnt[d] < cmax[d]) mcnt[d] = mcnt[d] + 1;
                if (acc) begin
                    mv[d]   = 1;
                    midx[d] = ref_idx(v, w_of[d], msb_of[d]);
                    mz[d]   = (v == 0);
                    mm[d]   = ($countones(v) >= 2);
                end else if (out_ready) begin
                    mv[d] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(mv[d]));
                chk($sformatf("in_ready[%0d]", d), 32'(ir[d]), 32'(!mv[d] || out_ready));
                chk($sformatf("err_cnt[%0d]", d), 32'(ec[d]), 32'(mcnt[d]));
                if (mv[d]) begin
                    chk($sformatf("out_idx[%0d]", d), 32'(oi[d]), 32'(midx[d]));
                    chk($sformatf("out_zero[%0d]", d), 32'(oz[d]), 32'(mz[d]));
                    chk($sformatf("out_multi[%0d]", d), 32'(om[d]), 32'(mm[d]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [7:0] v, input logic val, input logic rdy, input logic clr);
        in_vec    = v;
        in_valid  = val;
        out_ready = rdy;
        err_clr   = clr;
    endtask

    initial begin
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        step();
        en = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(ov[0]), 0);
        chk("rst_out_idx", 32'(oi[0]), 0);
        chk("rst_flags", 32'({oz[0], om[0]}), 0);
        chk("rst_err_cnt", 32'(ec[0]), 0);
        chk("rst_in_ready", 32'(ir[0]), 1);

        // one-hot walk, one result per cycle
        for (int k = 0; k < 8; k++) begin
            drive(8'(1 << k), 1'b1, 1'b1, 1'b0);
            step();
            chk("onehot_idx", 32'(oi[0]), k);
            chk("onehot_flags", 32'({oz[0], om[0], ov[0]}), 1);
        end

        drive(8'b00101100, 1'b1, 1'b1, 1'b0);
        step();
        chk("multi_msb_idx", 32'(oi[0]), 5);
        chk("multi_lsb_idx", 32'(oi[1]), 2);
        chk("multi_flag", 32'(om[0]), 1);
        chk("multi_err_cnt", 32'(ec[0]), 1);
        chk("model_msb_idx", 32'(midx[0]), 5);
        chk("model_lsb_idx", 32'(midx[1]), 2);

        drive(8'h00, 1'b1, 1'b1, 1'b0);
        step();
        chk("zero_flag", 32'(oz[0]), 1);
        chk("zero_idx", 32'(oi[0]), 0);
        chk("zero_multi", 32'(om[0]), 0);
        chk("zero_err_cnt", 32'(ec[0]), 1);
        chk("model_zero_cnt", 32'(mcnt[0]), 1);

        // backpressure
        drive(8'b01000000, 1'b1, 1'b1, 1'b0);
        step();
        chk("bp_first_idx", 32'(oi[0]), 6);
        drive(8'b00000010, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_idx", 32'(oi[0]), 6);
            chk("bp_in_ready", 32'(ir[0]), 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_idx", 32'(oi[0]), 1);
        in_valid = 1'b0;
        step();
        chk("bp_drained", 32'(ov[0]), 0);

        // saturation on the 2-bit counter
        drive(8'h00, 1'b0, 1'b1, 1'b1);
        step();
        chk("clr_small", 32'(ec[2]), 0);
        for (int k = 0; k < 5; k++) begin
            drive(8'b00000011, 1'b1, 1'b1, 1'b0);
            step();
            chk("sat_small", 32'(ec[2]), (k < 3) ? k + 1 : 3);
        end
        drive(8'b00000011, 1'b1, 1'b1, 1'b1);
        step();
        chk("clr_wins_small", 32'(ec[2]), 0);
        chk("clr_wins_main", 32'(ec[0]), 0);

        drive(8'b00010000, 1'b1, 1'b1, 1'b0);
        step();
        chk("w5_idx", 32'(oi[2]), 4);

        // reset while a result is held under backpressure
        drive(8'b00000110, 1'b1, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 32'(ov[0]), 0);
        chk("midrst_err", 32'(ec[0]), 0);
        chk("midrst_ready", 32'(ir[0]), 1);

        for (int n = 0; n < 3000; n++) begin
            int sel;
            logic [7:0] v;
            sel = $urandom_range(0, 3);
            if (sel == 0) v = 8'h00;
            else if (sel == 1) v = 8'(1 << $urandom_range(0, 7));
            else v = 8'($urandom_range(0, 255));
            drive(v, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        step();
        en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
